// File: rtl/acq_pkg.sv
// rtl/acq_pkg.sv - shared types, sensor register map and config table for acq_sequencer
package acq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CFG      = 3'd1,
    S_CFG_WAIT = 3'd2,
    S_ARM      = 3'd3,
    S_RD       = 3'd4,
    S_RD_WAIT  = 3'd5,
    S_DONE     = 3'd6,
    S_ERR      = 3'd7
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RETRY   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [7:0] REG_INT_EN    = 8'h02;
  localparam logic [7:0] REG_FIFO_DATA = 8'h07;
  localparam logic [7:0] REG_FIFO_CFG  = 8'h08;
  localparam logic [7:0] REG_MODE_CFG  = 8'h09;
  localparam logic [7:0] REG_SPO2_CFG  = 8'h0A;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } cfg_entry_t;

  // Interrupt enable goes last so the sensor only raises INT once fully configured.
  function automatic cfg_entry_t cfg_entry(input logic [1:0] idx);
    cfg_entry_t e;
    case (idx)
      2'd0:    e = '{addr: REG_FIFO_CFG, data: 8'h10};
      2'd1:    e = '{addr: REG_MODE_CFG, data: 8'h03};
      2'd2:    e = '{addr: REG_SPO2_CFG, data: 8'h27};
      default: e = '{addr: REG_INT_EN,   data: 8'h40};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/acq_int_sync.sv
// rtl/acq_int_sync.sv - two-flop synchroniser for the active-low sensor interrupt
module acq_int_sync (
  input  logic clk,
  input  logic reset,
  input  logic interupt,
  output logic int_n_sync
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta       <= 1'b1;
      int_n_sync <= 1'b1;
    end else begin
      meta       <= interupt;
      int_n_sync <= meta;
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// rtl/acq_sequencer.sv - acquisition run sequencer: sensor config writes, then FIFO burst reads per interrupt
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int TARGET_SAMPLES = 3750,
  parameter int BURST_LEN      = 32,
  parameter int NUM_CFG        = 4,
  parameter int MAX_RETRY      = 3,
  parameter int INT_TIMEOUT    = 5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        interupt,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_rw,
  output logic [7:0]  cmd_reg,
  output logic [7:0]  cmd_wdata,
  output logic [5:0]  cmd_len,
  input  logic        cmd_done,
  input  logic        cmd_err,
  input  logic [5:0]  rsp_samples,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [12:0] sample_count,
  output logic [2:0]  state_dbg
);

  localparam int TW = $clog2(INT_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [12:0] TGT = 13'(TARGET_SAMPLES);

  state_t        state, state_n;
  logic [1:0]    cfg_idx;
  logic [RW-1:0] retry;
  logic [TW-1:0] tmo_cnt;
  logic          abort_pend;
  logic          int_n_sync;

  logic          fire, start_run, abort_any, done_ok, retry_max, last_cfg;
  logic [12:0]   remaining;
  logic [5:0]    rd_len, acc;
  cfg_entry_t    entry;

  acq_int_sync u_int_sync (
    .clk        (clk),
    .reset      (reset),
    .interupt   (interupt),
    .int_n_sync (int_n_sync)
  );

  assign entry     = cfg_entry(cfg_idx);
  assign remaining = TGT - sample_count;
  assign rd_len    = (remaining > 13'(BURST_LEN)) ? 6'(BURST_LEN) : remaining[5:0];
  assign acc       = (rsp_samples < rd_len) ? rsp_samples : rd_len;
  assign fire      = cmd_valid && cmd_ready;
  assign start_run = (state == S_IDLE || state == S_DONE || state == S_ERR) && start && !abort;
  assign abort_any = abort || abort_pend;
  assign done_ok   = cmd_done && !cmd_err;
  assign retry_max = (retry == RW'(MAX_RETRY));
  assign last_cfg  = (cfg_idx == 2'(NUM_CFG - 1));

  assign busy      = !(state == S_IDLE || state == S_DONE || state == S_ERR);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);
  assign state_dbg = state;

  always_comb begin
    state_n   = state;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_reg   = 8'h00;
    cmd_wdata = 8'h00;
    cmd_len   = 6'd0;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start_run) state_n = S_CFG;
      S_CFG: begin
        cmd_valid = 1'b1;
        cmd_reg   = entry.addr;
        cmd_wdata = entry.data;
        // A handshake in the abort cycle still owes the master a completion.
        if (cmd_ready)  state_n = S_CFG_WAIT;
        else if (abort) state_n = S_IDLE;
      end
      S_CFG_WAIT: begin
        if (cmd_err)       state_n = abort_any ? S_IDLE : (retry_max ? S_ERR : S_CFG);
        else if (cmd_done) state_n = abort_any ? S_IDLE : (last_cfg ? S_ARM : S_CFG);
      end
      S_ARM: begin
        if (abort)                              state_n = S_IDLE;
        else if (!int_n_sync)                   state_n = S_RD;
        else if (tmo_cnt == TW'(INT_TIMEOUT-1)) state_n = S_ERR;
      end
      S_RD: begin
        cmd_valid = 1'b1;
        cmd_rw    = 1'b1;
        cmd_reg   = REG_FIFO_DATA;
        cmd_len   = rd_len;
        if (cmd_ready)  state_n = S_RD_WAIT;
        else if (abort) state_n = S_IDLE;
      end
      S_RD_WAIT: begin
        if (cmd_err)       state_n = abort_any ? S_IDLE : (retry_max ? S_ERR : S_RD);
        else if (cmd_done) state_n = abort_any ? S_IDLE :
                                     ((sample_count + 13'(acc) == TGT) ? S_DONE : S_ARM);
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cfg_idx      <= 2'd0;
      retry        <= '0;
      tmo_cnt      <= '0;
      abort_pend   <= 1'b0;
      sample_count <= 13'd0;
      err_code     <= ERR_NONE;
    end else begin
      state      <= state_n;
      tmo_cnt    <= (state == S_ARM && state_n == S_ARM) ? tmo_cnt + 1'b1 : '0;
      abort_pend <= (state_n == S_CFG_WAIT || state_n == S_RD_WAIT) && abort_any;
      if (start_run) begin
        cfg_idx      <= 2'd0;
        retry        <= '0;
        sample_count <= 13'd0;
        err_code     <= ERR_NONE;
      end else if (state == S_CFG_WAIT || state == S_RD_WAIT) begin
        if (cmd_err) begin
          if (!retry_max) retry <= retry + 1'b1;
        end else if (cmd_done) begin
          retry <= '0;
          if (state == S_CFG_WAIT) cfg_idx <= cfg_idx + 1'b1;
          else                     sample_count <= sample_count + 13'(acc);
        end
      end
      if (state_n == S_ERR && state != S_ERR)
        err_code <= (state == S_ARM) ? ERR_TIMEOUT : ERR_RETRY;
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// tb/tb_acq_sequencer.sv - directed self-checking bench for acq_sequencer with a command scoreboard
module tb_acq_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort, interupt;
  logic        cmd_valid, cmd_ready, cmd_rw, cmd_done, cmd_err;
  logic [7:0]  cmd_reg, cmd_wdata;
  logic [5:0]  cmd_len, rsp_samples;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [12:0] sample_count;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  acq_sequencer #(.INT_TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .interupt(interupt),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_reg(cmd_reg),
    .cmd_wdata(cmd_wdata), .cmd_len(cmd_len), .cmd_done(cmd_done), .cmd_err(cmd_err),
    .rsp_samples(rsp_samples), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .sample_count(sample_count), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic       rw;
    logic [7:0] ra;
    logic [7:0] wd;
    logic [5:0] len;
  } cmd_t;

  cmd_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         model;
  int         len;
  int         n;
  logic [5:0] last_len;
  logic [7:0] cfg_addr[4] = '{8'h08, 8'h09, 8'h0A, 8'h02};
  logic [7:0] cfg_data[4] = '{8'h10, 8'h03, 8'h27, 8'h40};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 0);
    check({tag, "_cmd_rw"},    32'(cmd_rw), 0);
    check({tag, "_cmd_reg"},   32'(cmd_reg), 0);
    check({tag, "_cmd_wdata"}, 32'(cmd_wdata), 0);
    check({tag, "_cmd_len"},   32'(cmd_len), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_error"},     32'(error), 0);
    check({tag, "_err_code"},  32'(err_code), 0);
    check({tag, "_count"},     32'(sample_count), 0);
    check({tag, "_state"},     32'(state_dbg), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: normal completion, 1: abort while waiting, 2: reset while waiting (left asserted)
  task automatic serve(input bit nack, input int rsp, input int mode);
    int   w;
    cmd_t e;
    w = 0;
    while (!cmd_valid && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("cmd_valid_wait", 32'(cmd_valid), 1);
    if (!cmd_valid) return;
    check("sb_depth", 32'(sb.size()), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("cmd_rw", 32'(cmd_rw), 32'(e.rw));
    check("cmd_reg", 32'(cmd_reg), 32'(e.ra));
    if (e.rw) check("cmd_len", 32'(cmd_len), 32'(e.len));
    else      check("cmd_wdata", 32'(cmd_wdata), 32'(e.wd));
    last_len = cmd_len;
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    interupt  = 1'b1;
    check("valid_drop", 32'(cmd_valid), 0);
    if (mode == 2) begin
      reset = 1'b1;
      @(negedge clk);
      return;
    end
    if (mode == 1) abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    cmd_done    = !nack;
    cmd_err     = nack;
    rsp_samples = 6'(rsp);
    @(negedge clk);
    cmd_done    = 1'b0;
    cmd_err     = 1'b0;
    rsp_samples = 6'd0;
  endtask

  task automatic push_cfg(input int i);
    sb.push_back({1'b0, cfg_addr[i], cfg_data[i], 6'd0});
  endtask

  task automatic push_rd(input int l);
    sb.push_back({1'b1, 8'h07, 8'h00, 6'(l)});
  endtask

  task automatic run_cfg();
    for (int i = 0; i < 4; i++) begin
      push_cfg(i);
      serve(1'b0, 0, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; interupt = 1'b1;
    cmd_ready = 1'b0; cmd_done = 1'b0; cmd_err = 1'b0; rsp_samples = 6'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Full run: config, then 118 bursts with the last one truncated to 6
    pulse_start();
    check("start_busy", 32'(busy), 1);
    check("start_state", 32'(state_dbg), 1);
    run_cfg();
    check("arm_state", 32'(state_dbg), 3);
    model = 0;
    for (int b = 0; b < 118; b++) begin
      len = (3750 - model > 32) ? 32 : 3750 - model;
      push_rd(len);
      interupt = 1'b0;
      serve(1'b0, len, 0);
      model += len;
      check("run_count", 32'(sample_count), 32'(model));
    end
    check("last_len", 32'(last_len), 6);
    check("run_done", 32'(done), 1);
    check("run_busy", 32'(busy), 0);
    check("run_final", 32'(sample_count), 3750);

    // NACK retries on config entries
    pulse_start();
    check("restart_count", 32'(sample_count), 0);
    push_cfg(0); serve(1'b0, 0, 0);
    push_cfg(1); serve(1'b1, 0, 0);
    push_cfg(1); serve(1'b1, 0, 0);
    push_cfg(1); serve(1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      push_cfg(2);
      serve(1'b1, 0, 0);
    end
    check("retry_error", 32'(error), 1);
    check("retry_code", 32'(err_code), 1);
    check("retry_valid", 32'(cmd_valid), 0);
    check("retry_busy", 32'(busy), 0);

    // Interrupt timeout in ARM
    pulse_start();
    check("err_cleared", 32'(err_code), 0);
    run_cfg();
    n = 0;
    while (!error && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 32'(n), 100);
    check("timeout_code", 32'(err_code), 2);
    check("timeout_valid", 32'(cmd_valid), 0);

    // Abort while a read is outstanding
    pulse_start();
    run_cfg();
    push_rd(32);
    interupt = 1'b0;
    serve(1'b0, 32, 1);
    check("abort_count", 32'(sample_count), 32);
    check("abort_state", 32'(state_dbg), 0);
    check("abort_busy", 32'(busy), 0);
    pulse_start();
    check("abort_restart", 32'(sample_count), 0);

    // Over-delivery clamps to cmd_len; reset mid-read
    run_cfg();
    push_rd(32);
    interupt = 1'b0;
    serve(1'b0, 40, 0);
    check("clamp_count", 32'(sample_count), 32);
    check("clamp_state", 32'(state_dbg), 3);
    push_rd(32);
    interupt = 1'b0;
    serve(1'b0, 0, 2);
    check_zero("midreset");
    reset = 1'b0;
    interupt = 1'b1;
    check("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
